// File: rtl/id_branch_unit_if.sv
// ---------------------------------------------------------------------------
// id_branch_unit_if
//   Fetch/redirect bus between IF_stage and the ID-side branch unit.
//
//   Signals (direction seen from the branch unit, modport master):
//     instruction   in   32        fetched word
//     next_pc       in   PC_WIDTH  PC+1 of the fetched word
//     if_valid      in   1         fetched word is real (IF_stage if_enable)
//     pc_write_ack  in   1         IF_stage writes its PC this cycle
//     branch_addr   out  PC_WIDTH  registered branch target
//     branch_taken  out  1         branch redirect request
//     jump_addr     out  PC_WIDTH  registered jump target
//     is_jump       out  1         jump redirect request
//
//   modport slave is the IF_stage view of the same bus.
// ---------------------------------------------------------------------------
interface id_branch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] next_pc;
    logic                if_valid;
    logic                pc_write_ack;
    logic [PC_WIDTH-1:0] branch_addr;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] jump_addr;
    logic                is_jump;

    modport master (
        input  instruction,
        input  next_pc,
        input  if_valid,
        input  pc_write_ack,
        output branch_addr,
        output branch_taken,
        output jump_addr,
        output is_jump
    );

    modport slave (
        output instruction,
        output next_pc,
        output if_valid,
        output pc_write_ack,
        input  branch_addr,
        input  branch_taken,
        input  jump_addr,
        input  is_jump
    );
endinterface

// File: rtl/id_branch_unit.sv
// ---------------------------------------------------------------------------
// id_branch_unit
//   ID-side partner of IF_stage. Holds the IF/ID pipeline register, decodes
//   J/BEQ/BNE and raises a registered redirect request (branch or jump) that
//   stays stable until IF_stage acknowledges its PC write. While a redirect
//   is pending every fetched word is squashed to NOP_INSTRUCTION.
//
//   Ports:
//     clk             in   1         rising-edge clock
//     rst             in   1         asynchronous, active-low reset
//     fetch           if   master    fetch/redirect bus (see id_branch_unit_if)
//     rs_data         in   32        forwarded value of rs ([25:21])
//     rt_data         in   32        forwarded value of rt ([20:16])
//     id_instruction  out  32        IF/ID instruction
//     id_next_pc      out  PC_WIDTH  IF/ID PC+1
//     id_valid        out  1         IF/ID holds a real instruction
//     busy            out  1         redirect pending
//     err             out  1         sticky: redirect wait reached MAX_WAIT
// ---------------------------------------------------------------------------
module id_branch_unit #(
    parameter int unsigned PC_WIDTH        = 32,
    parameter logic [5:0]  OP_J            = 6'h02,
    parameter logic [5:0]  OP_BEQ          = 6'h04,
    parameter logic [5:0]  OP_BNE          = 6'h05,
    parameter int unsigned MAX_WAIT        = 15,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    id_branch_unit_if.master    fetch,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    output logic [31:0]         id_instruction,
    output logic [PC_WIDTH-1:0] id_next_pc,
    output logic                id_valid,
    output logic                busy,
    output logic                err
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t              state, state_nxt;
    logic [31:0]         instr_p1, instr_nxt;
    logic [PC_WIDTH-1:0] npc_p1, npc_nxt;
    logic                vld_p1, vld_nxt;
    logic [PC_WIDTH-1:0] baddr_q, baddr_nxt;
    logic [PC_WIDTH-1:0] jaddr_q, jaddr_nxt;
    logic                btaken_q, btaken_nxt;
    logic                jmp_q, jmp_nxt;
    logic [7:0]          wait_cnt, wait_cnt_nxt;
    logic                err_q, err_nxt;

    logic [5:0]          opcode;
    logic                take_jump;
    logic                take_branch;

    // PC-relative target: the offset is sign-extended to 32 bits, the add is
    // done at 32 bits and then truncated, which gives the mod 2^PC_WIDTH wrap.
    function automatic logic [PC_WIDTH-1:0] branch_target(
        input logic [PC_WIDTH-1:0] npc,
        input logic [15:0]         imm
    );
        logic signed [31:0] off;
        logic        [31:0] base;
        logic        [31:0] sum;
        off  = {{16{imm[15]}}, imm};
        base = 32'(npc);
        sum  = base + $unsigned(off);
        return sum[PC_WIDTH-1:0];
    endfunction

    // Absolute target: imm26 zero-extended, then cut to the PC width.
    function automatic logic [PC_WIDTH-1:0] jump_target(
        input logic [25:0] imm
    );
        logic [31:0] t;
        t = {6'b0, imm};
        return t[PC_WIDTH-1:0];
    endfunction

    // ---- stage p1: decode of the IF/ID register ----
    assign opcode      = instr_p1[31:26];
    assign take_jump   = vld_p1 && (opcode == OP_J);
    assign take_branch = vld_p1 && (((opcode == OP_BEQ) && (rs_data == rt_data)) ||
                                    ((opcode == OP_BNE) && (rs_data != rt_data)));

    always_comb begin
        state_nxt    = state;
        instr_nxt    = instr_p1;
        npc_nxt      = npc_p1;
        vld_nxt      = vld_p1;
        baddr_nxt    = baddr_q;
        jaddr_nxt    = jaddr_q;
        btaken_nxt   = btaken_q;
        jmp_nxt      = jmp_q;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;

        case (state)
            IDLE: begin
                if (take_jump || take_branch) begin
                    state_nxt = REDIRECT;
                    if (take_jump) begin
                        jaddr_nxt = jump_target(instr_p1[25:0]);
                        jmp_nxt   = 1'b1;
                    end else begin
                        baddr_nxt  = branch_target(npc_p1, instr_p1[15:0]);
                        btaken_nxt = 1'b1;
                    end
                    // The word behind the taken instruction is on the wrong path.
                    instr_nxt = NOP_INSTRUCTION;
                    vld_nxt   = 1'b0;
                end else begin
                    instr_nxt = fetch.if_valid ? fetch.instruction : NOP_INSTRUCTION;
                    npc_nxt   = fetch.next_pc;
                    vld_nxt   = fetch.if_valid;
                end
            end
            REDIRECT: begin
                // Squash everything, including the word seen on the ack edge.
                instr_nxt = NOP_INSTRUCTION;
                vld_nxt   = 1'b0;
                if (fetch.pc_write_ack) begin
                    state_nxt    = IDLE;
                    btaken_nxt   = 1'b0;
                    jmp_nxt      = 1'b0;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    if (wait_cnt != WAIT_LIMIT) begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                    // Covers both the edge that reaches the limit and saturation.
                    if (wait_cnt >= (WAIT_LIMIT - 8'd1)) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1 register: IF/ID, redirect request, watchdog ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            instr_p1 <= NOP_INSTRUCTION;
            npc_p1   <= '0;
            vld_p1   <= 1'b0;
            baddr_q  <= '0;
            jaddr_q  <= '0;
            btaken_q <= 1'b0;
            jmp_q    <= 1'b0;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            instr_p1 <= instr_nxt;
            npc_p1   <= npc_nxt;
            vld_p1   <= vld_nxt;
            baddr_q  <= baddr_nxt;
            jaddr_q  <= jaddr_nxt;
            btaken_q <= btaken_nxt;
            jmp_q    <= jmp_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    assign fetch.branch_addr  = baddr_q;
    assign fetch.branch_taken = btaken_q;
    assign fetch.jump_addr    = jaddr_q;
    assign fetch.is_jump      = jmp_q;

    assign id_instruction = instr_p1;
    assign id_next_pc     = npc_p1;
    assign id_valid       = vld_p1;
    assign busy           = (state == REDIRECT);
    assign err            = err_q;

endmodule
